// File: rtl/random_hflip.sv
// Random horizontal-flip stage: buffers each incoming row in a ping-pong pair and
// re-emits it, mirrored left-right when the per-image flip decision is set.
module random_hflip #(
    parameter int          IMG_W     = 28,
    parameter int          IMG_H     = 28,
    parameter int          DATA_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        flip_mode,
    input  logic [DATA_W-1:0] pixel_i,
    input  logic              pixel_valid_i,
    output logic [DATA_W-1:0] pixel_o,
    output logic              pixel_valid_o,
    output logic              image_done_o,
    output logic              flipped_o,
    output logic              busy_o
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMG_H - 1);
    localparam logic [15:0]      LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                flip_q, flip_d;
    logic [COL_W-1:0]    wr_col_q, wr_col_d;
    logic [ROW_W-1:0]    wr_row_q, wr_row_d;
    logic                wr_buf_q, wr_buf_d;
    logic                rd_active_q, rd_active_d;
    logic [COL_W-1:0]    rd_col_q, rd_col_d;
    logic                rd_buf_q, rd_buf_d;
    logic [DATA_W-1:0]   pixel_q, pixel_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic                image_done_q, image_done_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem_q [2][IMG_W];

    logic                wr_en_s;
    logic                wr_addr_buf_s;
    logic [COL_W-1:0]    wr_addr_col_s;
    logic                row_done_s;
    logic [COL_W-1:0]    rd_idx_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                rd_last_s;
    logic                draw_flip_s;

    // Write/read addressing and per-image flip draw
    always_comb begin
        wr_en_s = pixel_valid_i && (start || (state_q == ST_FILL));
        if (start) begin
            // a pixel arriving with start is column 0 of row 0 of the new image
            wr_addr_buf_s = 1'b0;
            wr_addr_col_s = '0;
        end else begin
            wr_addr_buf_s = wr_buf_q;
            wr_addr_col_s = wr_col_q;
        end
        row_done_s = wr_en_s && !start && (wr_col_q == LAST_COL);
        rd_idx_s   = flip_q ? (LAST_COL - rd_col_q) : rd_col_q;
        rd_data_s  = mem_q[rd_buf_q][rd_idx_s];
        rd_last_s  = rd_active_q && (rd_col_q == LAST_COL);
        case (flip_mode)
            2'b00:   draw_flip_s = 1'b0;
            2'b01:   draw_flip_s = 1'b1;
            default: draw_flip_s = lfsr_q[0];
        endcase
    end

    // Image-level state: filling rows, flushing the final row, or idle
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_FILL:  state_d = (row_done_s && (wr_row_q == LAST_ROW)) ? ST_FLUSH : ST_FILL;
                ST_FLUSH: state_d = rd_last_s ? ST_IDLE : ST_FLUSH;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Flip decision and LFSR, both updated only on start
    always_comb begin
        lfsr_d = lfsr_q;
        flip_d = flip_q;
        if (start) begin
            lfsr_d = lfsr_next(lfsr_q);
            flip_d = draw_flip_s;
        end else begin
            lfsr_d = lfsr_q;
            flip_d = flip_q;
        end
    end

    // Write-side column/row/buffer counters
    always_comb begin
        wr_col_d = wr_col_q;
        wr_row_d = wr_row_q;
        wr_buf_d = wr_buf_q;
        if (start) begin
            wr_col_d = pixel_valid_i ? COL_W'(1) : '0;
            wr_row_d = '0;
            wr_buf_d = 1'b0;
        end else if (row_done_s) begin
            wr_col_d = '0;
            wr_row_d = (wr_row_q == LAST_ROW) ? '0 : (wr_row_q + ROW_W'(1));
            wr_buf_d = ~wr_buf_q;
        end else if (wr_en_s) begin
            wr_col_d = wr_col_q + COL_W'(1);
        end else begin
            wr_col_d = wr_col_q;
        end
    end

    // Read side: a completed row starts a fresh W-cycle read of its buffer
    always_comb begin
        rd_active_d = rd_active_q;
        rd_col_d    = rd_col_q;
        rd_buf_d    = rd_buf_q;
        if (start) begin
            rd_active_d = 1'b0;
            rd_col_d    = '0;
        end else if (row_done_s) begin
            // may coincide with the final load of the previous row; the new row wins
            rd_active_d = 1'b1;
            rd_col_d    = '0;
            rd_buf_d    = wr_buf_q;
        end else if (rd_active_q) begin
            rd_active_d = !rd_last_s;
            rd_col_d    = rd_last_s ? '0 : (rd_col_q + COL_W'(1));
        end else begin
            rd_active_d = 1'b0;
        end
    end

    // Registered output stage
    always_comb begin
        pixel_valid_d = rd_active_q && !start;
        pixel_d       = pixel_valid_d ? rd_data_s : pixel_q;
        image_done_d  = pixel_valid_d && rd_last_s && (state_q == ST_FLUSH);
        if (start) begin
            busy_d = 1'b1;
        end else if (image_done_q) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // State and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= LFSR_SEED;
            flip_q        <= 1'b0;
            wr_col_q      <= '0;
            wr_row_q      <= '0;
            wr_buf_q      <= 1'b0;
            rd_active_q   <= 1'b0;
            rd_col_q      <= '0;
            rd_buf_q      <= 1'b0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            image_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            flip_q        <= flip_d;
            wr_col_q      <= wr_col_d;
            wr_row_q      <= wr_row_d;
            wr_buf_q      <= wr_buf_d;
            rd_active_q   <= rd_active_d;
            rd_col_q      <= rd_col_d;
            rd_buf_q      <= rd_buf_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            image_done_q  <= image_done_d;
            busy_q        <= busy_d;
        end
    end

    // Ping-pong row storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_q[wr_addr_buf_s][wr_addr_col_s] <= pixel_i;
        end
    end

    assign pixel_o       = pixel_q;
    assign pixel_valid_o = pixel_valid_q;
    assign image_done_o  = image_done_q;
    assign flipped_o     = flip_q;
    assign busy_o        = busy_q;

    random_hflip_chk u_chk (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pixel_valid_o (pixel_valid_q),
        .image_done_o  (image_done_q),
        .busy_o        (busy_q)
    );

endmodule

// Output-protocol properties of random_hflip.
module random_hflip_chk (
    input logic clk,
    input logic reset,
    input logic start,
    input logic pixel_valid_o,
    input logic image_done_o,
    input logic busy_o
);

    a_done_with_valid: assert property (@(posedge clk) disable iff (reset)
        image_done_o |-> pixel_valid_o);

    a_valid_in_busy: assert property (@(posedge clk) disable iff (reset)
        pixel_valid_o |-> busy_o);

    a_busy_drops: assert property (@(posedge clk) disable iff (reset)
        (image_done_o && !start) |=> !busy_o);

endmodule

// File: tb/tb_random_hflip.sv
// Randomized bench for random_hflip against a timed-queue reference model.
module tb_random_hflip;

    localparam int W = 28;
    localparam int H = 28;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] flip_mode;
    logic [7:0] pixel_i;
    logic       pixel_valid_i;
    logic [7:0] pixel_o;
    logic       pixel_valid_o;
    logic       image_done_o;
    logic       flipped_o;
    logic       busy_o;

    random_hflip #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .LFSR_SEED(16'hACE1)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .flip_mode     (flip_mode),
        .pixel_i       (pixel_i),
        .pixel_valid_i (pixel_valid_i),
        .pixel_o       (pixel_o),
        .pixel_valid_o (pixel_valid_o),
        .image_done_o  (image_done_o),
        .flipped_o     (flipped_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: every completed row becomes W timed output entries.
    typedef struct {
        int unsigned at_edge;
        logic [7:0]  pix;
        logic        done;
    } ent_t;

    ent_t        sched[$];
    logic [7:0]  rowbuf[$];
    int unsigned n_edge = 0;
    int          cnt = 0;
    bit          filling = 0;
    bit          cur_flip = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    bit          prev_done = 0;
    logic        exp_valid = 0, exp_done = 0, exp_flip = 0, exp_busy = 0;
    logic [7:0]  exp_pix = 0;
    int          obs_out = 0, obs_done = 0;

    task automatic model_edge(input logic st, input logic v, input logic [7:0] p,
                              input logic rst, input logic [1:0] mode);
        ent_t e;
        n_edge++;
        if (rst) begin
            sched.delete(); rowbuf.delete();
            cnt = 0; filling = 0; m_lfsr = 16'hACE1; prev_done = 0;
            exp_valid = 0; exp_done = 0; exp_flip = 0; exp_busy = 0; exp_pix = 0;
            return;
        end
        if (st) begin
            sched.delete(); rowbuf.delete();
            cnt = 0; filling = 1;
            cur_flip = (mode == 2'b00) ? 1'b0 : (mode == 2'b01) ? 1'b1 : m_lfsr[0];
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            exp_flip = cur_flip;
            exp_busy = 1;
        end else if (prev_done) begin
            exp_busy = 0;
        end
        exp_valid = 0;
        exp_done  = 0;
        if (sched.size() > 0 && sched[0].at_edge == n_edge) begin
            e = sched.pop_front();
            exp_valid = 1; exp_pix = e.pix; exp_done = e.done;
        end
        prev_done = exp_done;
        if (v && filling) begin
            rowbuf.push_back(p);
            cnt++;
            if (rowbuf.size() == W) begin
                for (int c = 0; c < W; c++) begin
                    e.at_edge = n_edge + 1 + c;
                    e.pix     = cur_flip ? rowbuf[W-1-c] : rowbuf[c];
                    e.done    = (cnt == W*H) && (c == W-1);
                    sched.push_back(e);
                end
                rowbuf.delete();
                if (cnt == W*H) filling = 0;
            end
        end
    endtask

    task automatic step(input logic st, input logic v, input logic [7:0] p, input logic rst);
        start = st; pixel_valid_i = v; pixel_i = p; reset = rst;
        @(posedge clk);
        model_edge(st, v, p, rst, flip_mode);
        @(negedge clk);
        check("valid", pixel_valid_o, exp_valid);
        check("pixel", pixel_o, exp_pix);
        check("done", image_done_o, exp_done);
        check("flipped", flipped_o, exp_flip);
        check("busy", busy_o, exp_busy);
        if (pixel_valid_o === 1'b1) obs_out++;
        if (image_done_o === 1'b1) obs_done++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    // start pulse, then npix pixels with gap_pct percent idle cycles in between
    task automatic feed_image(input logic [1:0] mode, input int gap_pct, input int npix,
                              input bit seq, input bit first_valid);
        int k = 0;
        logic [7:0] pv;
        flip_mode = mode;
        pv = seq ? 8'(k) : 8'($urandom);
        step(1'b1, first_valid, pv, 1'b0);
        if (first_valid) k++;
        while (k < npix) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                step(1'b0, 1'b0, 8'($urandom), 1'b0);
            end else begin
                pv = seq ? 8'(k) : 8'($urandom);
                step(1'b0, 1'b1, pv, 1'b0);
                k++;
            end
        end
    endtask

    initial begin
        flip_mode = 2'b00;
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);

        // always flip, back-to-back sequential pixels
        obs_out = 0; obs_done = 0;
        feed_image(2'b01, 0, W*H, 1'b1, 1'b0);
        idle(40);
        check("s1_outs", 32'(obs_out), 32'(W*H));
        check("s1_dones", 32'(obs_done), 32'd1);
        check("s1_flip", 32'(flipped_o), 32'd1);

        // never flip
        obs_out = 0; obs_done = 0;
        feed_image(2'b00, 0, W*H, 1'b1, 1'b0);
        idle(40);
        check("s2_outs", 32'(obs_out), 32'(W*H));
        check("s2_dones", 32'(obs_done), 32'd1);
        check("s2_flip", 32'(flipped_o), 32'd0);

        // LFSR-driven decisions from the seed: 1, 0, 0
        step(1'b0, 1'b0, 8'h00, 1'b1);
        feed_image(2'b10, 0, W*H, 1'b0, 1'b1);
        idle(35);
        check("s3_flip0", 32'(flipped_o), 32'd1);
        feed_image(2'b10, 0, W*H, 1'b0, 1'b0);
        idle(35);
        check("s3_flip1", 32'(flipped_o), 32'd0);
        feed_image(2'b11, 0, W*H, 1'b0, 1'b0);
        idle(35);
        check("s3_flip2", 32'(flipped_o), 32'd0);

        // random valid gaps
        obs_out = 0; obs_done = 0;
        feed_image(2'b01, 50, W*H, 1'b1, 1'b0);
        idle(40);
        check("s4_outs", 32'(obs_out), 32'(W*H));
        check("s4_dones", 32'(obs_done), 32'd1);

        // abort after 300 pixels, then a full image with surplus pixels
        obs_done = 0;
        feed_image(2'b01, 0, 300, 1'b0, 1'b0);
        obs_out = 0;
        feed_image(2'b10, 10, W*H + 20, 1'b0, 1'b1);
        idle(40);
        check("s5_outs", 32'(obs_out), 32'(W*H));
        check("s5_dones", 32'(obs_done), 32'd1);

        // reset during the final-row flush
        obs_out = 0; obs_done = 0;
        feed_image(2'b01, 0, W*H, 1'b0, 1'b0);
        idle(10);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("s6_rst_valid", 32'(pixel_valid_o), 32'd0);
        check("s6_rst_pix", 32'(pixel_o), 32'd0);
        check("s6_rst_busy", 32'(busy_o), 32'd0);
        idle(40);
        check("s6_dones", 32'(obs_done), 32'd0);
        feed_image(2'b10, 0, W*H, 1'b0, 1'b0);
        idle(40);
        check("s6_seed_flip", 32'(flipped_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
